// File: rtl/dmem_waitstate_unit_if.sv
// MEM-stage data-memory bus: request fields from the pipeline, load result
// and status back from the wait-stated data memory.
interface dmem_waitstate_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic [XLEN-1:0] rdata;
    logic            resp_valid;
    logic            stall_out;
    logic            misalign_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  rdata, resp_valid, stall_out, misalign_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output rdata, resp_valid, stall_out, misalign_err
    );
endinterface

// File: rtl/dmem_waitstate_unit.sv
// Word-organised data RAM with WAIT_STATES extra cycles per access, RV32 b/h/w loads and stores.
// Define DMEM_ACCESS_COUNT_EN to enable the completed load/store counters.
module dmem_waitstate_unit #(
    parameter int XLEN        = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    dmem_waitstate_unit_if.slave bus,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count
);
    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W+1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [3:0]        cnt_q;
    logic              mis_q;
    logic [XLEN-1:0]   rdata_q;

    logic              stall;
    logic              access;
    logic              misaligned;

    logic [XLEN-1:0]   mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] widx;
    logic [XLEN-1:0]   rword;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [XLEN-1:0]   load_val;
    logic [3:0]        lane_en;
    logic [XLEN-1:0]   wrep;

    // funct3[1] marks a word access, funct3[1:0]==01 a halfword; this also covers hu and the sh alias
    assign misaligned = (bus.req_funct3[1] && (bus.req_addr[1:0] != 2'b00)) ||
                        ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]);

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        access    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.req_valid) begin
                    stall     = 1'b1;
                    state_nxt = misaligned ? DONE : BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (cnt_q == 4'd0) begin
                    access    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.req_valid) begin
                we_q    <= bus.req_we;
                f3_q    <= bus.req_funct3;
                addr_q  <= bus.req_addr[ADDR_W+1:0];
                wdata_q <= bus.req_wdata;
                cnt_q   <= 4'(WAIT_STATES);
                mis_q   <= misaligned;
            end
            if (state == BUSY && cnt_q != 4'd0)
                cnt_q <= cnt_q - 4'd1;
            if (access && !we_q)
                rdata_q <= load_val;
        end
    end

    // Upper address bits were dropped at capture, so the word index wraps modulo the RAM size
    assign widx     = addr_q[ADDR_W+1:2];
    assign rword    = mem[widx];
    assign half_sel = addr_q[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        byte_sel = rword[7:0];
        unique case (addr_q[1:0])
            2'd0: byte_sel = rword[7:0];
            2'd1: byte_sel = rword[15:8];
            2'd2: byte_sel = rword[23:16];
            2'd3: byte_sel = rword[31:24];
            default: byte_sel = rword[7:0];
        endcase
    end

    always_comb begin
        load_val = rword;
        unique case (f3_q)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_val = {24'd0, byte_sel};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = rword;
        endcase
    end

    always_comb begin
        lane_en = 4'b0001 << addr_q[1:0];
        wrep    = {4{wdata_q[7:0]}};
        if (f3_q[1]) begin
            lane_en = '1;
            wrep    = wdata_q;
        end else if (f3_q[0]) begin
            lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
            wrep    = {2{wdata_q[15:0]}};
        end
    end

    // A reset landing on the access edge discards the pending store
    always_ff @(posedge clk) begin
        if (access && we_q && !rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (lane_en[i])
                    mem[widx][8*i +: 8] <= wrep[8*i +: 8];
            end
        end
    end

`ifdef DMEM_ACCESS_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (access) begin
            if (we_q)
                wr_count <= wr_count + 32'd1;
            else
                rd_count <= rd_count + 32'd1;
        end
    end
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

    assign bus.rdata        = rdata_q;
    assign bus.resp_valid   = (state == DONE);
    assign bus.misalign_err = (state == DONE) && mis_q;
    assign bus.stall_out    = stall;
endmodule

// File: tb/tb_dmem_waitstate_unit.sv
// Directed bench: instance A (1024 words, 2 wait states) and instance B (16 words, 0 wait states).
module tb_dmem_waitstate_unit;
    logic        clk = 1'b0;
    logic        rst_a, rst_b;
    logic        va, vb;
    logic        t_we;
    logic [2:0]  t_f3;
    logic [31:0] t_addr, t_wdata;
    logic        sel;

    logic [31:0] rd_a, wr_a, rd_b, wr_b;

    int passed = 0;
    int total  = 0;

    dmem_waitstate_unit_if #(.XLEN(32)) if_a ();
    dmem_waitstate_unit_if #(.XLEN(32)) if_b ();

    assign if_a.req_valid  = va;
    assign if_a.req_we     = t_we;
    assign if_a.req_funct3 = t_f3;
    assign if_a.req_addr   = t_addr;
    assign if_a.req_wdata  = t_wdata;
    assign if_b.req_valid  = vb;
    assign if_b.req_we     = t_we;
    assign if_b.req_funct3 = t_f3;
    assign if_b.req_addr   = t_addr;
    assign if_b.req_wdata  = t_wdata;

    dmem_waitstate_unit #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(2)) dut_a (
        .clk(clk), .rst(rst_a), .bus(if_a.slave), .rd_count(rd_a), .wr_count(wr_a)
    );

    dmem_waitstate_unit #(.XLEN(32), .DEPTH_WORDS(16), .WAIT_STATES(0)) dut_b (
        .clk(clk), .rst(rst_b), .bus(if_b.slave), .rd_count(rd_b), .wr_count(wr_b)
    );

    logic        m_stall, m_resp, m_mis;
    logic [31:0] m_rdata;
    assign m_stall = sel ? if_b.stall_out    : if_a.stall_out;
    assign m_resp  = sel ? if_b.resp_valid   : if_a.resp_valid;
    assign m_mis   = sel ? if_b.misalign_err : if_a.misalign_err;
    assign m_rdata = sel ? if_b.rdata        : if_a.rdata;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Runs one access; returns stall cycles seen, the completion rdata and misalign flag
    task automatic access(input logic b, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int stalls, output logic [31:0] rd, output logic mis);
        logic got;
        sel = b;
        @(negedge clk);
        t_we = we; t_f3 = f3; t_addr = addr; t_wdata = wdata;
        if (b) vb = 1'b1; else va = 1'b1;
        stalls = 0; got = 1'b0; rd = '0; mis = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            #1;
            if (m_stall) stalls++;
            if (m_resp) begin
                got = 1'b1;
                rd  = m_rdata;
                mis = m_mis;
                va  = 1'b0;
                vb  = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        va = 1'b0; vb = 1'b0;
        check("completed", {31'd0, got}, 32'd1);
        @(negedge clk); #1;
        check("resp_one_cycle", {31'd0, m_resp}, 32'd0);
    endtask

    int          st;
    logic [31:0] rv;
    logic        mf;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; va = 1'b0; vb = 1'b0; sel = 1'b0;
        t_we = 1'b0; t_f3 = 3'b010; t_addr = '0; t_wdata = '0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        #1;
        check("rst_stall", {31'd0, if_a.stall_out}, 32'd0);
        check("rst_resp", {31'd0, if_a.resp_valid}, 32'd0);
        check("rst_mis", {31'd0, if_a.misalign_err}, 32'd0);
        check("rst_rdata", if_a.rdata, 32'd0);
        check("rst_rd_count", rd_a, 32'd0);
        check("rst_wr_count", wr_a, 32'd0);

        // sw / lw round trip
        access(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, st, rv, mf);
        check("sw_stalls", st, 32'd4);
        check("sw_mis", {31'd0, mf}, 32'd0);
        access(0, 0, 3'b010, 32'h10, 32'h0, st, rv, mf);
        check("lw_stalls", st, 32'd4);
        check("lw_data", rv, 32'hDEADBEEF);

        // byte store and signed/unsigned byte loads
        access(0, 1, 3'b010, 32'h20, 32'h44332211, st, rv, mf);
        access(0, 1, 3'b000, 32'h21, 32'hFFFFFF80, st, rv, mf);
        access(0, 0, 3'b000, 32'h21, 32'h0, st, rv, mf);
        check("lb", rv, 32'hFFFFFF80);
        access(0, 0, 3'b100, 32'h21, 32'h0, st, rv, mf);
        check("lbu", rv, 32'h00000080);
        access(0, 0, 3'b010, 32'h20, 32'h0, st, rv, mf);
        check("sb_lanes", rv, 32'h44338011);

        // upper halfword store
        access(0, 1, 3'b010, 32'h30, 32'h11223344, st, rv, mf);
        access(0, 1, 3'b001, 32'h32, 32'h00008001, st, rv, mf);
        access(0, 0, 3'b001, 32'h32, 32'h0, st, rv, mf);
        check("lh", rv, 32'hFFFF8001);
        access(0, 0, 3'b101, 32'h32, 32'h0, st, rv, mf);
        check("lhu", rv, 32'h00008001);
        access(0, 0, 3'b010, 32'h30, 32'h0, st, rv, mf);
        check("sh_lanes", rv, 32'h80013344);

        // misaligned accesses
        access(0, 0, 3'b010, 32'h13, 32'h0, st, rv, mf);
        check("mis_lw_flag", {31'd0, mf}, 32'd1);
        check("mis_lw_stalls", st, 32'd1);
        check("mis_lw_rdata_held", rv, 32'h80013344);
        check("mis_flag_cleared", {31'd0, if_a.misalign_err}, 32'd0);
        access(0, 1, 3'b001, 32'h31, 32'h0000FFFF, st, rv, mf);
        check("mis_sh_flag", {31'd0, mf}, 32'd1);
        access(0, 0, 3'b010, 32'h30, 32'h0, st, rv, mf);
        check("mis_sh_no_write", rv, 32'h80013344);
`ifdef DMEM_ACCESS_COUNT_EN
        check("rd_count_a", rd_a, 32'd8);
        check("wr_count_a", wr_a, 32'd5);
`else
        check("rd_count_tied", rd_a, 32'd0);
        check("wr_count_tied", wr_a, 32'd0);
`endif

        // reset in the 2nd BUSY cycle of a store
        access(0, 1, 3'b010, 32'h40, 32'hCAFEF00D, st, rv, mf);
        sel = 1'b0;
        @(negedge clk);
        t_we = 1'b1; t_f3 = 3'b010; t_addr = 32'h40; t_wdata = 32'h12345678; va = 1'b1;
        @(negedge clk);
        @(negedge clk); #1;
        check("busy2_stall", {31'd0, if_a.stall_out}, 32'd1);
        rst_a = 1'b1; va = 1'b0;
        @(negedge clk); #1;
        check("rst_mid_stall", {31'd0, if_a.stall_out}, 32'd0);
        check("rst_mid_resp", {31'd0, if_a.resp_valid}, 32'd0);
        check("rst_mid_rdata", if_a.rdata, 32'd0);
        rst_a = 1'b0;
        access(0, 0, 3'b010, 32'h40, 32'h0, st, rv, mf);
        check("rst_store_dropped", rv, 32'hCAFEF00D);
`ifdef DMEM_ACCESS_COUNT_EN
        check("rd_count_after_rst", rd_a, 32'd1);
        check("wr_count_after_rst", wr_a, 32'd0);
`endif

        // small RAM, zero wait states, address wrap
        access(1, 1, 3'b010, 32'h44, 32'hA5A5A5A5, st, rv, mf);
        check("b_sw_stalls", st, 32'd2);
        access(1, 0, 3'b010, 32'h04, 32'h0, st, rv, mf);
        check("b_lw_stalls", st, 32'd2);
        check("b_wrap_data", rv, 32'hA5A5A5A5);
`ifdef DMEM_ACCESS_COUNT_EN
        check("b_rd_count", rd_b, 32'd1);
        check("b_wr_count", wr_b, 32'd1);
`else
        check("b_rd_count_tied", rd_b, 32'd0);
        check("b_wr_count_tied", wr_b, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
